// File: rtl/stopwatch_ctrl_if.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_if
// Groups the stopwatch controller's button inputs and counter-chain/display
// control outputs into a single bundle.
//   BTN_PAUSE  : raw start/pause button (active-high, bouncing)
//   BTN_RESET  : raw clear button (active-high, bouncing)
//   TICK       : one-cycle count-enable pulse to the counter chain
//   PAUSE      : level, high while the counter chain must hold
//   CLR        : one-cycle synchronous clear to the counter chain
//   REFRESH    : one-cycle display digit-scan pulse
//   STATE      : controller state (00 IDLE, 01 RUN, 10 PAUSED)
// Modports: master = button source / output consumer, slave = controller.
// -----------------------------------------------------------------------------
interface stopwatch_ctrl_if;
  logic       BTN_PAUSE;
  logic       BTN_RESET;
  logic       TICK;
  logic       PAUSE;
  logic       CLR;
  logic       REFRESH;
  logic [1:0] STATE;

  modport master (output BTN_PAUSE, BTN_RESET,
                  input  TICK, PAUSE, CLR, REFRESH, STATE);
  modport slave  (input  BTN_PAUSE, BTN_RESET,
                  output TICK, PAUSE, CLR, REFRESH, STATE);
endinterface

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Stopwatch controller: synchronizes and debounces two buttons, runs the
// IDLE/RUN/PAUSED state machine, and generates the count-enable tick, the
// counter-chain clear and the free-running display refresh pulse.
// Ports:
//   CLK    : system clock, all logic on its rising edge
//   RESET  : synchronous active-high reset
//   bus    : stopwatch_ctrl_if.slave (buttons in; TICK, PAUSE, CLR,
//            REFRESH, STATE out -- all registered)
// Parameters: DIV_TICK, DIV_REFRESH, DB_CYCLES (each >= 2).
// Build option: define STOPWATCH_CTRL_DB_BYPASS_EN to remove the debounce
// stage (the debounced level becomes the registered synchronizer output and
// DB_CYCLES is ignored). Default build keeps full debounce.
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int DIV_TICK    = 10_000_000,
  parameter int DIV_REFRESH = 100_000,
  parameter int DB_CYCLES   = 1_000_000
) (
  input  logic             CLK,
  input  logic             RESET,
  stopwatch_ctrl_if.slave  bus
);

  localparam int TW = $clog2(DIV_TICK);
  localparam int RW = $clog2(DIV_REFRESH);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_t;

  // bit 0 = pause button, bit 1 = reset button
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    db_lvl;
  logic [1:0]    db_prev;
  logic [1:0]    press;
  logic          pause_press;
  logic          reset_press;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] tick_cnt;
  logic [RW-1:0] ref_cnt;
  logic          tick;
  logic          pause;
  logic          clr;
  logic          refresh;

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_a <= 2'b00;
      sync_b <= 2'b00;
    end else begin
      sync_a <= {bus.BTN_RESET, bus.BTN_PAUSE};
      sync_b <= sync_a;
    end
  end

`ifdef STOPWATCH_CTRL_DB_BYPASS_EN
  // Debounce bypassed: debounced level follows the synchronizer output.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      db_lvl <= 2'b00;
    end else begin
      db_lvl <= sync_b;
    end
  end
`else
  localparam int CW = $clog2(DB_CYCLES);
  logic [CW-1:0] stab_cnt [2];

  // Debounce: accept a new level only after DB_CYCLES consecutive mismatches;
  // any agreeing cycle restarts the count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      db_lvl <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        stab_cnt[i] <= {CW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] != db_lvl[i]) begin
          if (stab_cnt[i] == CW'(DB_CYCLES - 1)) begin
            db_lvl[i]   <= sync_b[i];
            stab_cnt[i] <= {CW{1'b0}};
          end else begin
            stab_cnt[i] <= stab_cnt[i] + CW'(1);
          end
        end else begin
          stab_cnt[i] <= {CW{1'b0}};
        end
      end
    end
  end
`endif

  // Previous debounced level, used to detect the rising edge only.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      db_prev <= 2'b00;
    end else begin
      db_prev <= db_lvl;
    end
  end

  // Press event is high for the single cycle the debounced level first reads 1.
  assign press       = db_lvl & ~db_prev;
  assign pause_press = press[0];
  assign reset_press = press[1];

  // Next-state logic; a reset press overrides a simultaneous pause press.
  always_comb begin
    state_next = state;
    if (reset_press) begin
      state_next = IDLE;
    end else if (pause_press) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSED;
        PAUSED:  state_next = RUN;
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = state;
    end
  end

  // State register and registered counter-chain controls. TICK and PAUSE are
  // derived from the next state so TICK can never coincide with PAUSE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      tick_cnt <= {TW{1'b0}};
      tick     <= 1'b0;
      pause    <= 1'b1;
      clr      <= 1'b1;
    end else begin
      state <= state_next;
      pause <= (state_next != RUN);
      clr   <= reset_press;
      tick  <= (state == RUN) && (state_next == RUN) &&
               (tick_cnt == TW'(DIV_TICK - 1));
      // Divider clears in IDLE, advances in RUN and holds across PAUSED so a
      // resume keeps the partial interval.
      if (state_next == IDLE) begin
        tick_cnt <= {TW{1'b0}};
      end else if (state == RUN) begin
        if (tick_cnt == TW'(DIV_TICK - 1)) begin
          tick_cnt <= {TW{1'b0}};
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end else begin
        tick_cnt <= tick_cnt;
      end
    end
  end

  // Free-running display refresh divider, independent of the buttons.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ref_cnt <= {RW{1'b0}};
      refresh <= 1'b0;
    end else begin
      refresh <= (ref_cnt == RW'(DIV_REFRESH - 1));
      if (ref_cnt == RW'(DIV_REFRESH - 1)) begin
        ref_cnt <= {RW{1'b0}};
      end else begin
        ref_cnt <= ref_cnt + RW'(1);
      end
    end
  end

  assign bus.STATE   = state;
  assign bus.TICK    = tick;
  assign bus.PAUSE   = pause;
  assign bus.CLR     = clr;
  assign bus.REFRESH = refresh;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed self-checking bench for stopwatch_ctrl with DB_CYCLES=4,
// DIV_TICK=5, DIV_REFRESH=3. Inputs are driven 1 time unit after a rising
// edge and outputs are sampled at the same point, so "after edge k" below
// means the values registered on the k-th edge since the stimulus change.
// LAT is the number of edges from a button rise to the resulting state
// change: 2 synchronizer + 4 debounce + 1 FSM, or 2 + 1 + 1 with bypass.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;
  localparam int DB = 4;
  localparam int DT = 5;
  localparam int DR = 3;
`ifdef STOPWATCH_CTRL_DB_BYPASS_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 7;
`endif
  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_PAUSED = 2'b10;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .DIV_TICK    (DT),
    .DIV_REFRESH (DR),
    .DB_CYCLES   (DB)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs during reset, CLR drop on release, refresh cadence from reset.
  task automatic test_reset();
    logic [4:0] got, exp;
    logic       exp_r;
    rst = 1'b1;
    bus.BTN_PAUSE = 1'b0;
    bus.BTN_RESET = 1'b0;
    repeat (3) step();
    got = {bus.STATE, bus.TICK, bus.PAUSE, bus.CLR};
    exp = {S_IDLE, 1'b0, 1'b1, 1'b1};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL reset_outputs {STATE,TICK,PAUSE,CLR} got=%b exp=%b", got, exp);
    end
    tests_run++;
    if (bus.REFRESH !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_refresh got=%b exp=0", bus.REFRESH);
    end
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      got   = {bus.STATE, bus.TICK, bus.PAUSE, bus.CLR};
      exp   = {S_IDLE, 1'b0, 1'b1, 1'b0};
      exp_r = (k % 3 == 0);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL post_reset k=%0d got=%b exp=%b", k, got, exp);
      end
      tests_run++;
      if (bus.REFRESH !== exp_r) begin
        tests_failed++;
        $display("FAIL refresh_cadence k=%0d got=%b exp=%b", k, bus.REFRESH, exp_r);
      end
    end
  endtask

  // Bouncing pause button (2 high / 2 low) never produces a press.
  task automatic test_bounce();
    logic [2:0] got, exp;
    for (int k = 0; k < 28; k++) begin
      bus.BTN_PAUSE = (k < 20) && ((k / 2) % 2 == 0);
      step();
      got = {bus.STATE, bus.CLR};
      exp = {S_IDLE, 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL bounce k=%0d {STATE,CLR} got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  // Reset press while already IDLE still yields one CLR pulse.
  task automatic test_clear_in_idle();
    logic [4:0] got, exp;
    bus.BTN_RESET = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 8) bus.BTN_RESET = 1'b0;
      got = {bus.STATE, bus.TICK, bus.PAUSE, bus.CLR};
      exp = {S_IDLE, 1'b0, 1'b1, (k == LAT)};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL clear_idle k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  // Held pause button: single IDLE->RUN, then TICK every 5th cycle.
  // Ends with the tick divider at 4.
  task automatic test_press_hold();
    logic [4:0] got, exp;
    logic       exp_t;
    bus.BTN_PAUSE = 1'b1;
    for (int k = 1; k <= LAT + 19; k++) begin
      step();
      if (k == 10) bus.BTN_PAUSE = 1'b0;
      exp_t = (k >= LAT + 5) && ((k - LAT - 5) % 5 == 0);
      got = {bus.STATE, bus.TICK, bus.PAUSE, bus.CLR};
      exp = {(k >= LAT) ? S_RUN : S_IDLE, exp_t, (k < LAT), 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL press_hold k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  // Pause while the divider reads 2, sit in PAUSED, resume: first TICK
  // arrives 2 cycles after re-entering RUN.
  task automatic test_pause_resume();
    logic [4:0] got, exp;
    logic       exp_t;
    repeat ((14 - LAT) % 5) step();
    bus.BTN_PAUSE = 1'b1;
    for (int k = 1; k <= 62; k++) begin
      step();
      if (k == 10) bus.BTN_PAUSE = 1'b0;
      if (k >= LAT) begin
        got = {bus.STATE, bus.TICK, bus.PAUSE, bus.CLR};
        exp = {S_PAUSED, 1'b0, 1'b1, 1'b0};
        tests_run++;
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL paused k=%0d got=%b exp=%b", k, got, exp);
        end
      end
    end
    bus.BTN_PAUSE = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 10) bus.BTN_PAUSE = 1'b0;
      exp_t = (k >= LAT + 2) && ((k - LAT - 2) % 5 == 0);
      got = {bus.STATE, bus.TICK, bus.PAUSE, bus.CLR};
      exp = {(k >= LAT) ? S_RUN : S_PAUSED, exp_t, (k < LAT), 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL resume k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  // Both buttons rise together in RUN: reset wins, one CLR, divider back
  // to 0 (next RUN entry ticks after a full 5 cycles).
  task automatic test_both_buttons();
    logic [4:0] got, exp;
    logic       exp_t;
    bus.BTN_PAUSE = 1'b1;
    bus.BTN_RESET = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 10) begin
        bus.BTN_PAUSE = 1'b0;
        bus.BTN_RESET = 1'b0;
      end
      if (k >= LAT) begin
        got = {bus.STATE, bus.TICK, bus.PAUSE, bus.CLR};
        exp = {S_IDLE, 1'b0, 1'b1, (k == LAT)};
        tests_run++;
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL both_buttons k=%0d got=%b exp=%b", k, got, exp);
        end
      end
    end
    bus.BTN_PAUSE = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 10) bus.BTN_PAUSE = 1'b0;
      exp_t = (k >= LAT + 5) && ((k - LAT - 5) % 5 == 0);
      got = {bus.STATE, bus.TICK, bus.PAUSE, bus.CLR};
      exp = {(k >= LAT) ? S_RUN : S_IDLE, exp_t, (k < LAT), 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL divider_cleared k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  // RESET during RUN with a reset press still debouncing.
  task automatic test_reset_mid_press();
    logic [4:0] got, exp;
    logic       exp_r;
    bus.BTN_RESET = 1'b1;
    step();
    step();
    rst = 1'b1;
    bus.BTN_RESET = 1'b0;
    step();
    got = {bus.STATE, bus.TICK, bus.PAUSE, bus.CLR};
    exp = {S_IDLE, 1'b0, 1'b1, 1'b1};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL mid_press_reset got=%b exp=%b", got, exp);
    end
    tests_run++;
    if (bus.REFRESH !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_press_refresh got=%b exp=0", bus.REFRESH);
    end
    step();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      got   = {bus.STATE, bus.TICK, bus.PAUSE, bus.CLR};
      exp   = {S_IDLE, 1'b0, 1'b1, 1'b0};
      exp_r = (k % 3 == 0);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL after_mid_reset k=%0d got=%b exp=%b", k, got, exp);
      end
      tests_run++;
      if (bus.REFRESH !== exp_r) begin
        tests_failed++;
        $display("FAIL after_mid_refresh k=%0d got=%b exp=%b", k, bus.REFRESH, exp_r);
      end
    end
  endtask

`ifdef STOPWATCH_CTRL_DB_BYPASS_EN
  // Two-cycle reset pulse with debounce bypassed: CLR 4 edges after rise.
  task automatic test_bypass_pulse();
    logic exp_c;
    bus.BTN_RESET = 1'b1;
    step();
    step();
    bus.BTN_RESET = 1'b0;
    for (int k = 3; k <= 10; k++) begin
      step();
      exp_c = (k == 4);
      tests_run++;
      if (bus.CLR !== exp_c) begin
        tests_failed++;
        $display("FAIL bypass_clr k=%0d got=%b exp=%b", k, bus.CLR, exp_c);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef STOPWATCH_CTRL_DB_BYPASS_EN
    test_bounce();
`endif
    test_clear_in_idle();
    test_press_hold();
    test_pause_resume();
    test_both_buttons();
    test_reset_mid_press();
`ifdef STOPWATCH_CTRL_DB_BYPASS_EN
    test_bypass_pulse();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
